native_mem_slave: RTL and testbench

Single-port slave for the CPU's PicoRV32-style native memory interface: consumes `mem_valid`/`mem_addr`/`mem_wdata`/`mem_wstrb` and returns `mem_ready`/`mem_rdata`. It decodes each request to one of three targets:
- word-addressed instruction/data RAM,
- a GPIO output register,
- a free-running cycle timer.

It inserts a configurable number of wait states so CPU fetch and load/store stalling can be exercised.

---
 rtl/mem_map_pkg.sv | 37 +++
 rtl/word_ram.sv | 27 ++
 rtl/native_mem_slave.sv | 149 ++++++++++++++
 tb/tb_native_mem_slave.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mem_map_pkg.sv
// Address map, state/target encodings and the address decoder shared by the
// native memory slave and its RAM.
package mem_map_pkg;

    localparam logic [31:0] RAM_BASE   = 32'h0000_0000;
    localparam logic [31:0] GPIO_ADDR  = 32'h1000_0000;
    localparam logic [31:0] TIMER_ADDR = 32'h1000_0004;
    localparam logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } slave_state_t;

    typedef enum logic [1:0] {
        TGT_RAM,
        TGT_GPIO,
        TGT_TIMER,
        TGT_NONE
    } target_t;

    // Byte-lane bits [1:0] never take part in the decode.
    function automatic target_t decode(input logic [31:0] addr, input logic [31:0] ram_bytes);
        target_t tgt;
        tgt = TGT_NONE;
        if ((addr - RAM_BASE) < ram_bytes) begin
            tgt = TGT_RAM;
        end else if (addr[31:2] == GPIO_ADDR[31:2]) begin
            tgt = TGT_GPIO;
        end else if (addr[31:2] == TIMER_ADDR[31:2]) begin
            tgt = TGT_TIMER;
        end
        return tgt;
    endfunction

endpackage

// File: rtl/word_ram.sv
// Word-wide RAM with synchronous read and per-byte write enables.
module word_ram #(
   parameter int    MEM_WORDS = 1024,
   parameter string INIT_FILE = ""
) (
   input  logic                         clk,
   input  logic                         re,
   input  logic [3:0]                   we,
   input  logic [$clog2(MEM_WORDS)-1:0] addr,
   input  logic [31:0]                  wdata,
   output logic [31:0]                  rdata
);

   logic [31:0] mem [MEM_WORDS];

   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem[addr];
      end
      for (int i = 0; i < 4; i++) begin
         if (we[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/native_mem_slave.sv
// PicoRV32-style native memory slave: RAM, GPIO register and cycle timer with
// WAIT_CYCLES wait states. Define MEM_ERR_EN for unmapped-access error reporting.
//
// state | meaning
// IDLE  | waiting for mem_valid; request latched and decoded on acceptance
// WAIT  | counting down wait states
// RESP  | mem_ready pulse; writes commit on the edge leaving this state
module native_mem_slave
    import mem_map_pkg::*;
#(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [31:0] gpio_out,
    output logic        err
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

`ifdef MEM_ERR_EN
    localparam logic [31:0] UNMAPPED_RDATA = ERR_RDATA;
`else
    localparam logic [31:0] UNMAPPED_RDATA = 32'h0;
`endif

    slave_state_t  state, state_nxt;
    logic [3:0]    wait_cnt, wait_cnt_nxt;
    target_t       tgt_req, tgt_cur, tgt_q;
    logic [AW-1:0] idx_q, ram_addr;
    logic [31:0]   wdata_q, rdata_q, timer, gpio_q, ram_rdata;
    logic [3:0]    wstrb_q, ram_we;
    logic          accept, capture, commit, ram_re;
    logic          unused_inputs;

    assign unused_inputs = mem_instr;

    assign tgt_req  = decode(mem_addr, RAM_BYTES);
    assign accept   = (state == IDLE) && mem_valid;
    assign capture  = (state_nxt == RESP);
    // A reset arriving during RESP must not let the write land.
    assign commit   = (state == RESP) && reset_n;
    assign tgt_cur  = (state == IDLE) ? tgt_req : tgt_q;
    assign ram_addr = (state == IDLE) ? mem_addr[AW+1:2] : idx_q;
    assign ram_re   = capture && (tgt_cur == TGT_RAM);
    assign ram_we   = (commit && tgt_q == TGT_RAM) ? wstrb_q : 4'b0000;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE: begin
                if (mem_valid) begin
                    wait_cnt_nxt = WAIT_LOAD;
                    state_nxt    = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                wait_cnt_nxt = wait_cnt - 4'd1;
                if (wait_cnt == 4'd1) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            timer    <= '0;
            gpio_q   <= '0;
            rdata_q  <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            timer    <= timer + 32'd1;
            if (capture) begin
                case (tgt_cur)
                    TGT_GPIO:  rdata_q <= gpio_q;
                    TGT_TIMER: rdata_q <= timer;
                    TGT_NONE:  rdata_q <= UNMAPPED_RDATA;
                    default:   rdata_q <= '0;
                endcase
            end
            if (commit && tgt_q == TGT_GPIO) begin
                for (int i = 0; i < 4; i++) begin
                    if (wstrb_q[i]) begin
                        gpio_q[8*i +: 8] <= wdata_q[8*i +: 8];
                    end
                end
            end
        end
    end

    // Request fields are only meaningful after acceptance, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            tgt_q   <= tgt_req;
            idx_q   <= mem_addr[AW+1:2];
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
        end
    end

    word_ram #(
        .MEM_WORDS (MEM_WORDS)
    ) u_ram (
        .clk   (clk),
        .re    (ram_re),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign mem_ready = (state == RESP);
    assign mem_rdata = mem_ready ? ((tgt_q == TGT_RAM) ? ram_rdata : rdata_q) : 32'h0;
    assign gpio_out  = gpio_q;

`ifdef MEM_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (state == RESP && tgt_q == TGT_NONE) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_native_mem_slave.sv
// Directed bench for native_mem_slave: one instance with no wait states, one
// with three, sharing clock and reset.
module tb_native_mem_slave;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        v     [2];
    logic        instr [2];
    logic [31:0] a     [2];
    logic [31:0] wd    [2];
    logic [3:0]  ws    [2];
    logic        ready [2];
    logic [31:0] rdata [2];
    logic [31:0] gpio  [2];
    logic        err   [2];

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MEM_ERR_EN
    localparam logic [31:0] EXP_UNMAPPED = 32'hDEAD_BEEF;
    localparam logic [31:0] EXP_ERR      = 32'd1;
`else
    localparam logic [31:0] EXP_UNMAPPED = 32'h0;
    localparam logic [31:0] EXP_ERR      = 32'd0;
`endif

    always #5 clk = ~clk;

    native_mem_slave #(.MEM_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .mem_valid(v[0]), .mem_instr(instr[0]),
        .mem_addr(a[0]), .mem_wdata(wd[0]), .mem_wstrb(ws[0]), .mem_ready(ready[0]),
        .mem_rdata(rdata[0]), .gpio_out(gpio[0]), .err(err[0])
    );

    native_mem_slave #(.MEM_WORDS(256), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .mem_valid(v[1]), .mem_instr(instr[1]),
        .mem_addr(a[1]), .mem_wdata(wd[1]), .mem_wstrb(ws[1]), .mem_ready(ready[1]),
        .mem_rdata(rdata[1]), .gpio_out(gpio[1]), .err(err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One transaction; checks latency, the single ready pulse and idle rdata.
    task automatic do_req(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rd);
        int lat;
        v[d] = 1'b1; a[d] = addr; wd[d] = wdata; ws[d] = wstrb; instr[d] = (wstrb == 4'b0);
        @(posedge clk); #1;
        v[d] = 1'b0; ws[d] = 4'b0; instr[d] = 1'b0;
        lat = 0;
        while (!ready[d] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), (d == 0) ? 32'd0 : 32'd3);
        rd = rdata[d];
        @(posedge clk); #1;
        chk("ready_single_pulse", 32'(ready[d]), 32'd0);
        chk("rdata_zero_when_idle", rdata[d], 32'h0);
    endtask

    initial begin
        logic [31:0] rd, t1, t2, t3;
        int pulses;

        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b0; instr[i] = 1'b0; a[i] = '0; wd[i] = '0; ws[i] = '0;
        end
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_ready", 32'(ready[i]), 32'd0);
            chk("reset_rdata", rdata[i], 32'h0);
            chk("reset_gpio", gpio[i], 32'h0);
            chk("reset_err", 32'(err[i]), 32'd0);
        end
        reset_n = 1'b1;

        // zero wait states: write then read back
        do_req(0, 32'h10, 32'h1234_5678, 4'b1111, rd);
        do_req(0, 32'h10, 32'h0, 4'b0000, rd);
        chk("ram_readback", rd, 32'h1234_5678);
        do_req(0, 32'h10, 32'h0BAD_F00D, 4'b1111, rd);
        chk("write_returns_prewrite", rd, 32'h1234_5678);

        // byte strobes
        do_req(0, 32'h20, 32'hFFFF_FFFF, 4'b1111, rd);
        do_req(0, 32'h20, 32'h0000_AB00, 4'b0010, rd);
        do_req(0, 32'h20, 32'h0, 4'b0000, rd);
        chk("byte_strobe", rd, 32'hFFFF_ABFF);

        // three wait states
        do_req(1, 32'h10, 32'hCAFE_0001, 4'b1111, rd);
        do_req(1, 32'h10, 32'h0, 4'b0000, rd);
        chk("ram_readback_w3", rd, 32'hCAFE_0001);

        // mem_valid held high through RESP yields one pulse
        v[1] = 1'b1; a[1] = 32'h10; ws[1] = 4'b0;
        pulses = 0; rd = '0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (ready[1]) begin
                pulses++;
                rd = rdata[1];
            end
            if (i == 4) v[1] = 1'b0;
        end
        chk("held_valid_pulses", 32'(pulses), 32'd1);
        chk("held_valid_rdata", rd, 32'hCAFE_0001);

        // GPIO
        do_req(0, 32'h1000_0000, 32'h0000_00A5, 4'b0001, rd);
        chk("gpio_write", gpio[0], 32'h0000_00A5);
        do_req(0, 32'h1000_0000, 32'h0033_0000, 4'b0100, rd);
        do_req(0, 32'h1000_0000, 32'h0, 4'b0000, rd);
        chk("gpio_readback", rd, 32'h0033_00A5);
        chk("gpio_other_dut", gpio[1], 32'h0);

        // timer: reads accepted 10 cycles apart, then a dropped write
        do_req(0, 32'h1000_0004, 32'h0, 4'b0000, t1);
        repeat (8) @(posedge clk);
        #1;
        do_req(0, 32'h1000_0004, 32'h0, 4'b0000, t2);
        chk("timer_delta", t2 - t1, 32'd10);
        do_req(0, 32'h1000_0004, 32'hFFFF_0000, 4'b1111, rd);
        do_req(0, 32'h1000_0004, 32'h0, 4'b0000, t3);
        chk("timer_write_dropped", t3 - t2, 32'd4);

        // unmapped access
        do_req(0, 32'h2000_0000, 32'h0, 4'b0000, rd);
        chk("unmapped_rdata", rd, EXP_UNMAPPED);
        chk("unmapped_err", 32'(err[0]), EXP_ERR);
        do_req(0, 32'h10, 32'h0, 4'b0000, rd);
        chk("err_sticky", 32'(err[0]), EXP_ERR);
        chk("err_other_dut", 32'(err[1]), 32'd0);

        // reset in the middle of a write's wait states
        do_req(1, 32'h40, 32'h1111_1111, 4'b1111, rd);
        v[1] = 1'b1; a[1] = 32'h40; wd[1] = 32'h2222_2222; ws[1] = 4'b1111;
        @(posedge clk); #1;
        v[1] = 1'b0; ws[1] = 4'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ready[1]) pulses++;
        end
        chk("reset_no_ready", 32'(pulses), 32'd0);
        chk("reset_gpio_cleared", gpio[0], 32'h0);
        chk("reset_err_cleared", 32'(err[0]), 32'd0);
        reset_n = 1'b1;
        do_req(0, 32'h1000_0004, 32'h0, 4'b0000, rd);
        chk("timer_restart", rd, 32'h0);
        do_req(1, 32'h40, 32'h0, 4'b0000, rd);
        chk("aborted_write_discarded", rd, 32'h1111_1111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
